multi_button_debouncer: RTL and testbench
=========================================

Name: multi_button_debouncer

Overview:
- Parametrised N-channel debouncer for front-panel push buttons.
- Per channel: synchronises the raw pin and filters bounce with a stability counter.
- Per channel: emits a debounced level plus single-cycle press, release, long-press and auto-repeat event pulses.
- Sits between the raw keypad pins and the sale-terminal control FSM, replacing per-button debouncer instances.

Parameters:
- N_BUTTONS, 4: number of independent channels (>=1).
- BOUNCE_DELAY, 100000: consecutive stable cycles required before the clean level changes (>=1).
- HOLD_DELAY, 50000000: cycles a debounced press must persist before LongPressPulse (>=1).
- REPEAT_PERIOD, 10000000: cycles between RepeatPulse events after long press; 0 disables repeat.
- ACTIVE_LOW, 1: 1 = raw pin low means pressed; 0 = raw pin high means pressed.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- NoisyButtonIn  in  N_BUTTONS  raw asynchronous button pins
- CleanButtonOut  out  N_BUTTONS  debounced level, 1 = pressed (polarity normalised)
- PressPulse  out  N_BUTTONS  1-cycle pulse on debounced 0->1
- ReleasePulse  out  N_BUTTONS  1-cycle pulse on debounced 1->0
- LongPressPulse  out  N_BUTTONS  1-cycle pulse when press held HOLD_DELAY cycles
- RepeatPulse  out  N_BUTTONS  1-cycle pulse every REPEAT_PERIOD cycles after long press

Behaviour:
- One clock, CLK. Synchronous active-high reset, RST; no asynchronous reset anywhere.
- Reset (RST=1 at an edge), all channels:
  - sync flops and last-sample cleared to the released state;
  - all counters = 0;
  - CleanButtonOut = 0; all pulse outputs = 0.
  - Reset mid-bounce or mid-hold aborts everything; no pulses are emitted on the reset edge or the first edge after it.
- Input path per channel:
  - 2-flop synchroniser, then polarity normalise: pressed = ACTIVE_LOW ? ~pin : pin.
  - Channels are fully independent; no shared counters.
- Debounce per channel:
  - Stability counter width $clog2(BOUNCE_DELAY+1).
  - On any cycle where the synchronised value differs from the stored last sample: last <= new value, counter <= 0.
  - Otherwise the counter increments, saturating at BOUNCE_DELAY.
  - When counter == BOUNCE_DELAY and last != CleanButtonOut, CleanButtonOut <= last.
  - Latency: raw level first captured at edge E0 and held stable -> CleanButtonOut changes at edge E0+BOUNCE_DELAY+2.
  - A glitch of any length shorter than that restarts the count. No output change ever occurs from a glitch.
- Edge pulses:
  - PressPulse/ReleasePulse are asserted for exactly the one cycle following the CleanButtonOut transition, i.e. registered alongside it.
- Hold FSM per channel, states IDLE, HELD, REPEAT:
  - IDLE: waits for a debounced press; on press -> HELD, hold counter = 0.
  - HELD: counter increments each cycle. At count HOLD_DELAY-1: LongPressPulse for 1 cycle, counter = 0, then -> REPEAT if REPEAT_PERIOD>0, else stay in HELD with the counter frozen (no further pulses).
  - REPEAT: counter increments. At REPEAT_PERIOD-1: RepeatPulse for 1 cycle, counter = 0, remain in REPEAT.
  - Debounced release in any state -> IDLE, counter = 0. ReleasePulse still fires.
  - Release on the same cycle a long/repeat pulse would fire: release wins, no long/repeat pulse.
- Hold counter width: $clog2(max(HOLD_DELAY, REPEAT_PERIOD)+1). Neither counter ever wraps.
- PressPulse and LongPressPulse never coincide (HOLD_DELAY>=1).

Test Plan:
(N_BUTTONS=2, BOUNCE_DELAY=4, HOLD_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1)
- Reset:
  - Stimulus: RST high 3 cycles with pins=2'b00 (both pressed).
  - Response: all outputs 0 during reset and on the first edge after it. CleanButtonOut[1:0] rises at edge 6 after reset release (E0 = first sampled edge).
- Clean press ch0:
  - Stimulus: pin0 1->0 sampled at E0, held.
  - Response: CleanButtonOut[0]=1 at E0+6; PressPulse[0] high exactly 1 cycle; ch1 outputs unchanged.
- Bounce:
  - Stimulus: pin0 toggles 0,1,0,1 with 2-cycle spacing, then held 0.
  - Response: no output change until 6 edges after the final toggle; exactly one PressPulse.
- Long press with repeat:
  - Stimulus: ch0 held for 40 cycles after the debounced press.
  - Response: LongPressPulse at press+10 cycles; RepeatPulse at +13, +16, +19, … while held.
  - Then release: ReleasePulse once, no further repeats.
- Release collision:
  - Stimulus: a debounced release landing on the cycle LongPressPulse is due.
  - Response: ReleasePulse=1, LongPressPulse=0, FSM in IDLE.
- Reset mid-hold:
  - Stimulus: assert RST during REPEAT on ch1 while pin still pressed.
  - Response: all outputs 0.
  - After release of RST: a fresh press is detected at +6, with no stale repeat pulses.

Source files
------------

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer: 2-flop synchroniser, stability filter,
// edge pulses and a hold/auto-repeat FSM per channel, all channels independent.
module multi_button_debouncer #(
    parameter int N_BUTTONS     = 4,
    parameter int BOUNCE_DELAY  = 100000,
    parameter int HOLD_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_BUTTONS-1:0] NoisyButtonIn,
    output logic [N_BUTTONS-1:0] CleanButtonOut,
    output logic [N_BUTTONS-1:0] PressPulse,
    output logic [N_BUTTONS-1:0] ReleasePulse,
    output logic [N_BUTTONS-1:0] LongPressPulse,
    output logic [N_BUTTONS-1:0] RepeatPulse
);

    localparam int BW   = $clog2(BOUNCE_DELAY + 1);
    localparam int HMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [BW-1:0] BOUNCE_MAX  = BW'(BOUNCE_DELAY);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_DELAY - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_PERIOD - 1);
    // Raw pin level of a released button; XOR with it normalises to 1 = pressed.
    localparam logic          POLARITY    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        logic [1:0]    sync_r;
        logic          last_r;
        logic [BW-1:0] bcnt_r;
        logic          clean_r;
        logic          press_r;
        logic          release_r;
        hold_state_t   state_r;
        logic [HW-1:0] hcnt_r;
        logic          long_r;
        logic          repeat_r;
        logic          long_done_r;

        logic          sample_s;
        logic [BW-1:0] bcnt_next_s;
        logic          settle_s;
        logic          rise_s;
        logic          fall_s;

        // Next stability count and the debounced edge decided on this cycle.
        always_comb begin
            sample_s    = sync_r[1] ^ POLARITY;
            bcnt_next_s = (bcnt_r == BOUNCE_MAX) ? BOUNCE_MAX : bcnt_r + BW'(1);
            settle_s    = 1'b0;
            if ((sample_s == last_r) && (bcnt_next_s == BOUNCE_MAX) && (last_r != clean_r)) begin
                settle_s = 1'b1;
            end else begin
                settle_s = 1'b0;
            end
            rise_s = settle_s & last_r;
            fall_s = settle_s & ~last_r;
        end

        // Synchroniser, stability counter, debounced level and edge pulses.
        always_ff @(posedge CLK) begin
            if (RST) begin
                sync_r    <= {2{POLARITY}};
                last_r    <= 1'b0;
                bcnt_r    <= {BW{1'b0}};
                clean_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                sync_r <= {sync_r[0], NoisyButtonIn[i]};
                if (sample_s != last_r) begin
                    last_r <= sample_s;
                    bcnt_r <= {BW{1'b0}};
                end else begin
                    bcnt_r <= bcnt_next_s;
                end
                if (settle_s) begin
                    clean_r <= last_r;
                end
                press_r   <= rise_s;
                release_r <= fall_s;
            end
        end

        // Hold/repeat FSM; a debounced release in the same cycle suppresses any pulse.
        always_ff @(posedge CLK) begin
            if (RST) begin
                state_r     <= IDLE;
                hcnt_r      <= {HW{1'b0}};
                long_r      <= 1'b0;
                repeat_r    <= 1'b0;
                long_done_r <= 1'b0;
            end else begin
                long_r   <= 1'b0;
                repeat_r <= 1'b0;
                if (fall_s) begin
                    state_r     <= IDLE;
                    hcnt_r      <= {HW{1'b0}};
                    long_done_r <= 1'b0;
                end else begin
                    case (state_r)
                        IDLE: begin
                            hcnt_r      <= {HW{1'b0}};
                            long_done_r <= 1'b0;
                            if (rise_s) begin
                                state_r <= HELD;
                            end
                        end
                        HELD: begin
                            if (long_done_r) begin
                                hcnt_r <= hcnt_r;
                            end else if (hcnt_r == HOLD_LAST) begin
                                long_r <= 1'b1;
                                hcnt_r <= {HW{1'b0}};
                                if (REPEAT_PERIOD > 0) begin
                                    state_r <= REPEAT;
                                end else begin
                                    long_done_r <= 1'b1;
                                end
                            end else begin
                                hcnt_r <= hcnt_r + HW'(1);
                            end
                        end
                        REPEAT: begin
                            if (hcnt_r == REPEAT_LAST) begin
                                repeat_r <= 1'b1;
                                hcnt_r   <= {HW{1'b0}};
                            end else begin
                                hcnt_r <= hcnt_r + HW'(1);
                            end
                        end
                        default: begin
                            state_r <= IDLE;
                            hcnt_r  <= {HW{1'b0}};
                        end
                    endcase
                end
            end
        end

        assign CleanButtonOut[i] = clean_r;
        assign PressPulse[i]     = press_r;
        assign ReleasePulse[i]   = release_r;
        assign LongPressPulse[i] = long_r;
        assign RepeatPulse[i]    = repeat_r;
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Self-checking bench for multi_button_debouncer: directed scenarios plus random
// pin activity compared against a sample-window / hold-duration reference model.
module tb_multi_button_debouncer;

    localparam int N  = 2;
    localparam int B  = 4;
    localparam int H  = 10;
    localparam int R  = 3;
    localparam int AL = 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] NoisyButtonIn = 2'b11;
    logic [N-1:0] CleanButtonOut, PressPulse, ReleasePulse, LongPressPulse, RepeatPulse;

    multi_button_debouncer #(
        .N_BUTTONS(N), .BOUNCE_DELAY(B), .HOLD_DELAY(H), .REPEAT_PERIOD(R), .ACTIVE_LOW(AL)
    ) dut (
        .CLK(CLK), .RST(RST), .NoisyButtonIn(NoisyButtonIn),
        .CleanButtonOut(CleanButtonOut), .PressPulse(PressPulse), .ReleasePulse(ReleasePulse),
        .LongPressPulse(LongPressPulse), .RepeatPulse(RepeatPulse)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: history of captured pressed levels, newest at index 0.
    bit           hist [N][16];
    logic [N-1:0] e_clean = '0, e_press = '0, e_rel = '0, e_long = '0, e_rep = '0;
    int           press_t [N];

    function automatic logic [5*N-1:0] dut_vec();
        return {CleanButtonOut, PressPulse, ReleasePulse, LongPressPulse, RepeatPulse};
    endfunction

    function automatic logic [5*N-1:0] exp_vec();
        return {e_clean, e_press, e_rel, e_long, e_rep};
    endfunction

    task automatic model_edge(input bit rst, input logic [N-1:0] pins);
        bit v, stable, prev;
        int d;
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) hist[ch][k] = 1'b0;
                e_clean[ch] = 1'b0; e_press[ch] = 1'b0; e_rel[ch] = 1'b0;
                e_long[ch]  = 1'b0; e_rep[ch]   = 1'b0; press_t[ch] = 0;
            end else begin
                for (int k = 15; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = (AL != 0) ? ~pins[ch] : pins[ch];
                // Level seen at the filter is two captures old; it must have held B+1 captures.
                v = hist[ch][2];
                stable = 1'b1;
                for (int k = 2; k <= 2 + B; k++) if (hist[ch][k] != v) stable = 1'b0;
                prev = e_clean[ch];
                if (stable) e_clean[ch] = v;
                e_press[ch] = !prev && e_clean[ch];
                e_rel[ch]   = prev && !e_clean[ch];
                if (e_press[ch]) press_t[ch] = cyc;
                e_long[ch] = 1'b0;
                e_rep[ch]  = 1'b0;
                if (prev && e_clean[ch]) begin
                    d = cyc - press_t[ch];
                    e_long[ch] = (d == H);
                    e_rep[ch]  = (R > 0) && (d > H) && (((d - H) % R) == 0);
                end
            end
        end
    endtask

    task automatic step(input bit rst, input logic [N-1:0] pins);
        RST = rst;
        NoisyButtonIn = pins;
        @(posedge CLK);
        model_edge(rst, pins);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b00);
            n_cmp++;
            if (dut_vec() !== 10'd0) begin
                n_fail++; $display("FAIL reset_zero cyc=%0d got=%b exp=0", cyc, dut_vec());
            end
        end
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 2'b00);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (k == 1) begin
                n_cmp++;
                if (dut_vec() !== 10'd0) begin
                    n_fail++; $display("FAIL reset_first_edge got=%b exp=0", dut_vec());
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (CleanButtonOut !== 2'b00) begin
                    n_fail++; $display("FAIL reset_early_clean got=%b exp=00", CleanButtonOut);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if ({CleanButtonOut, PressPulse} !== 4'b1111) begin
                    n_fail++; $display("FAIL reset_rise got=%b exp=1111", {CleanButtonOut, PressPulse});
                end
            end
        end
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_rel_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int press_at = -1, np = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 2'b10);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL press_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            n_cmp++;
            if ({CleanButtonOut[1], PressPulse[1], ReleasePulse[1], LongPressPulse[1], RepeatPulse[1]} !== 5'b0) begin
                n_fail++; $display("FAIL press_ch1_quiet cyc=%0d got=%b exp=0", cyc, dut_vec());
            end
            if (PressPulse[0] === 1'b1) begin
                np++;
                if (press_at < 0) press_at = k;
            end
        end
        n_cmp++;
        if (press_at !== 7 || np !== 1) begin
            n_fail++; $display("FAIL press_timing got=at%0d/n%0d exp=at7/n1", press_at, np);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL press_rel_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_bounce();
        int press_at = -1, np = 0;
        logic [N-1:0] p;
        for (int k = 1; k <= 16; k++) begin
            p = ((k >= 3 && k <= 4) || (k >= 7 && k <= 8)) ? 2'b11 : 2'b10;
            step(1'b0, p);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (k < 15) begin
                n_cmp++;
                if (CleanButtonOut[0] !== 1'b0) begin
                    n_fail++; $display("FAIL bounce_early k=%0d got=1 exp=0", k);
                end
            end
            if (PressPulse[0] === 1'b1) begin
                np++;
                if (press_at < 0) press_at = k;
            end
        end
        n_cmp++;
        if (press_at !== 15 || np !== 1) begin
            n_fail++; $display("FAIL bounce_press got=at%0d/n%0d exp=at15/n1", press_at, np);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_rel_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_long_repeat();
        int long_at = -1, nlong = 0, first_rep = -1, nrep = 0, nrel = 0, rep_after = 0;
        for (int k = 1; k <= 47; k++) begin
            step(1'b0, 2'b10);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL long_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (LongPressPulse[0] === 1'b1) begin nlong++; long_at = k; end
            if (RepeatPulse[0] === 1'b1) begin
                nrep++;
                if (first_rep < 0) first_rep = k;
            end
        end
        n_cmp++;
        if (long_at !== 17 || nlong !== 1 || first_rep !== 20 || nrep !== 10) begin
            n_fail++;
            $display("FAIL long_repeat got=long%0d/n%0d rep%0d/n%0d exp=long17/n1 rep20/n10",
                     long_at, nlong, first_rep, nrep);
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL long_rel_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (nrel > 0 && RepeatPulse[0] === 1'b1) rep_after++;
            if (ReleasePulse[0] === 1'b1) nrel++;
        end
        n_cmp++;
        if (nrel !== 1 || rep_after !== 0) begin
            n_fail++; $display("FAIL long_release got=rel%0d/rep%0d exp=rel1/rep0", nrel, rep_after);
        end
    endtask

    task automatic test_release_collision();
        int npulse = 0, long_at = -1;
        for (int k = 1; k <= 22; k++) begin
            step(1'b0, (k <= 10) ? 2'b10 : 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL coll_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (k == 17) begin
                n_cmp++;
                if ({ReleasePulse[0], LongPressPulse[0]} !== 2'b10) begin
                    n_fail++; $display("FAIL coll_edge got=rel%b/long%b exp=rel1/long0", ReleasePulse[0], LongPressPulse[0]);
                end
            end
            if (LongPressPulse[0] === 1'b1 || RepeatPulse[0] === 1'b1) npulse++;
        end
        n_cmp++;
        if (npulse !== 0) begin
            n_fail++; $display("FAIL coll_no_pulse got=%0d exp=0", npulse);
        end
        for (int k = 1; k <= 28; k++) begin
            step(1'b0, (k <= 18) ? 2'b10 : 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL coll_again_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (LongPressPulse[0] === 1'b1 && long_at < 0) long_at = k;
        end
        n_cmp++;
        if (long_at !== 17) begin
            n_fail++; $display("FAIL coll_idle_restart got=%0d exp=17", long_at);
        end
    endtask

    task automatic test_reset_mid_hold();
        int press_at = -1, long_at = -1, early = 0;
        for (int k = 1; k <= 21; k++) begin
            step(1'b0, 2'b01);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL midrst_pre_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 2'b01);
            n_cmp++;
            if (dut_vec() !== 10'd0) begin
                n_fail++; $display("FAIL midrst_zero got=%b exp=0", dut_vec());
            end
        end
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 2'b01);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL midrst_post_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
            if (PressPulse[1] === 1'b1 && press_at < 0) press_at = k;
            if (LongPressPulse[1] === 1'b1 && long_at < 0) long_at = k;
            if (k < 17 && (RepeatPulse !== 2'b00 || LongPressPulse !== 2'b00)) early++;
        end
        n_cmp++;
        if (press_at !== 7 || long_at !== 17 || early !== 0) begin
            n_fail++; $display("FAIL midrst_fresh got=press%0d/long%0d/stale%0d exp=press7/long17/stale0",
                               press_at, long_at, early);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 2'b11);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL midrst_rel_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int remain [N];
        logic [N-1:0] pv = 2'b11;
        bit rst;
        for (int ch = 0; ch < N; ch++) remain[ch] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (remain[ch] == 0) begin
                    pv[ch] = 1'($urandom_range(0, 1));
                    remain[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(7, 30))
                                                             : int'($urandom_range(1, 5));
                end
                remain[ch]--;
            end
            rst = ($urandom_range(0, 199) == 0);
            step(rst, pv);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_vec cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_collision();
        test_reset_mid_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
